eth_tx_arb: RTL and testbench

//  Packet-level round-robin arbiter that shares the single eth_tx byte port between N requesters
//  (RX loopback, external TX, eth_tx_tpg). It grants one requester per packet and keeps SOP..EOP contiguous.
//  It enforces a minimum idle gap between packets and polices framing.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_rr_pick.sv | 30 +++
 rtl/eth_tx_arb.sv | 146 ++++++++++++++
 tb/tb_eth_tx_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX packet arbiter.
// A byte slot is {SOP, EOP, data[7:0]}.
package eth_pkg;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } eth_byte_t;

  localparam int cSOP_BIT = 9;
  localparam int cEOP_BIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOP,
    XFER,
    GAP
  } tx_arb_state_t;

  // Synthetic terminator emitted on underrun so eth_tx can close the frame.
  localparam eth_byte_t cCLOSE_BYTE = '{sop: 1'b0, eop: 1'b1, data: 8'h00};

endpackage

// File: rtl/eth_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational; returns one-hot, index and any-request flag.
module eth_rr_pick #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    logic [W-1:0] j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level round-robin arbiter sharing the eth_tx byte port between requesters,
// with start timeout, framing repair, inter-frame gap and drop counting.
//
//  state    | meaning
//  IDLE     | no grant; sample Req and pick next requester round-robin
//  WAIT_SOP | grant held, waiting for grantee's SOP byte (start timer running)
//  XFER     | forwarding grantee bytes until EOP, SOP violation or underrun
//  GAP      | grant dropped, enforcing the idle gap before returning to IDLE
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int pNum_Req       = 3,
  parameter int pIFG_Cycles    = 24,
  parameter int pStart_Timeout = 64
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [pNum_Req-1:0]   Req,
  output logic [pNum_Req-1:0]   Gnt,
  input  logic [10*pNum_Req-1:0] Byte_In,
  input  logic [pNum_Req-1:0]   Byte_Valid_In,
  output logic [9:0]            Eth_Byte,
  output logic                  Eth_Byte_Valid,
  output logic                  Err_Framing,
  output logic                  Err_Timeout,
  output logic [15:0]           Drop_Cnt
);

  localparam int cIdxW = $clog2(pNum_Req);
  localparam logic [15:0] cWAIT_LOAD = 16'(pStart_Timeout - 1);
  localparam logic [15:0] cGAP_LOAD  = (pIFG_Cycles == 0) ? 16'd0 : 16'(pIFG_Cycles - 1);

  tx_arb_state_t     state;
  logic [cIdxW-1:0]  gnt_idx;
  logic [cIdxW-1:0]  rr_ptr;
  logic [cIdxW-1:0]  next_ptr;
  logic [15:0]       tmr;
  logic              enter_gap;

  logic [pNum_Req-1:0] pick_onehot;
  logic [cIdxW-1:0]    pick_idx;
  logic                pick_any;

  eth_byte_t slot [pNum_Req];
  eth_byte_t g_byte;
  logic      g_valid;

  for (genvar i = 0; i < pNum_Req; i++) begin : g_slot
    assign slot[i] = {Byte_In[10*i + cSOP_BIT], Byte_In[10*i + cEOP_BIT], Byte_In[10*i +: 8]};
  end

  assign g_byte   = slot[gnt_idx];
  assign g_valid  = Byte_Valid_In[gnt_idx];
  assign next_ptr = (gnt_idx == cIdxW'(pNum_Req - 1)) ? '0 : gnt_idx + 1'b1;

  eth_rr_pick #(
    .N (pNum_Req),
    .W (cIdxW)
  ) u_pick (
    .req    (Req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Every way a grant can terminate funnels into one GAP entry.
  always_comb begin
    enter_gap = 1'b0;
    case (state)
      WAIT_SOP: enter_gap = (g_valid && g_byte.sop) ? g_byte.eop : (tmr == '0);
      XFER:     enter_gap = !g_valid || g_byte.sop || g_byte.eop;
      default:  enter_gap = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      Gnt            <= '0;
      gnt_idx        <= '0;
      rr_ptr         <= '0;
      tmr            <= '0;
      Eth_Byte       <= '0;
      Eth_Byte_Valid <= 1'b0;
      Err_Framing    <= 1'b0;
      Err_Timeout    <= 1'b0;
    end else begin
      Eth_Byte       <= '0;
      Eth_Byte_Valid <= 1'b0;
      Err_Framing    <= 1'b0;
      Err_Timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            Gnt     <= pick_onehot;
            gnt_idx <= pick_idx;
            tmr     <= cWAIT_LOAD;
            state   <= WAIT_SOP;
          end
        end
        WAIT_SOP: begin
          if (g_valid && g_byte.sop) begin
            Eth_Byte       <= g_byte;
            Eth_Byte_Valid <= 1'b1;
            state          <= XFER;
          end else begin
            if (g_valid) Err_Framing <= 1'b1;
            if (tmr == '0) Err_Timeout <= 1'b1;
            else tmr <= tmr - 1'b1;
          end
        end
        XFER: begin
          Eth_Byte_Valid <= 1'b1;
          if (!g_valid) begin
            Eth_Byte    <= cCLOSE_BYTE;
            Err_Framing <= 1'b1;
          end else if (g_byte.sop) begin
            // Early SOP: close the current frame with this byte's data.
            Eth_Byte    <= {1'b0, 1'b1, g_byte.data};
            Err_Framing <= 1'b1;
          end else begin
            Eth_Byte <= g_byte;
          end
        end
        GAP: begin
          if (tmr == '0) state <= IDLE;
          else tmr <= tmr - 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (enter_gap) begin
        Gnt    <= '0;
        rr_ptr <= next_ptr;
        tmr    <= cGAP_LOAD;
        state  <= GAP;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) Drop_Cnt <= '0;
    else if (|(Byte_Valid_In & ~Gnt) && (Drop_Cnt != 16'hFFFF)) Drop_Cnt <= Drop_Cnt + 16'd1;
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle with a packet-level reference model.
module tb_eth_tx_arb;

  localparam int N   = 3;
  localparam int IFG = 24;
  localparam int TMO = 64;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [N-1:0]    Req = '0;
  logic [N-1:0]    Gnt;
  logic [10*N-1:0] Byte_In = '0;
  logic [N-1:0]    Byte_Valid_In = '0;
  logic [9:0]      Eth_Byte;
  logic            Eth_Byte_Valid;
  logic            Err_Framing;
  logic            Err_Timeout;
  logic [15:0]     Drop_Cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_eop = -1000;
  int last_sop = -1000;
  int terr_seen = 0;
  int outv_seen = 0;

  always #5 Clk = ~Clk;

  eth_tx_arb #(
    .pNum_Req       (N),
    .pIFG_Cycles    (IFG),
    .pStart_Timeout (TMO)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Req            (Req),
    .Gnt            (Gnt),
    .Byte_In        (Byte_In),
    .Byte_Valid_In  (Byte_Valid_In),
    .Eth_Byte       (Eth_Byte),
    .Eth_Byte_Valid (Eth_Byte_Valid),
    .Err_Framing    (Err_Framing),
    .Err_Timeout    (Err_Timeout),
    .Drop_Cnt       (Drop_Cnt)
  );

  // Reference model: who owns the port, how long they have waited, how much gap is left.
  // phase: 0 free, 1 granted awaiting start, 2 packet in flight, 3 enforced gap
  logic [N-1:0] m_gnt   = '0;
  logic [9:0]   m_byte  = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr  = 1'b0;
  logic         m_terr  = 1'b0;
  logic [15:0]  m_drop  = '0;
  int           m_phase = 0;
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_wait  = 0;
  int           m_gap   = 0;

  task automatic model_release();
    m_gnt   = '0;
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_phase = 3;
    m_gap   = 0;
  endtask

  task automatic model_step();
    logic       v;
    logic [9:0] b;
    if (Rst) begin
      m_gnt = '0; m_byte = '0; m_valid = 1'b0; m_ferr = 1'b0; m_terr = 1'b0;
      m_drop = '0; m_phase = 0; m_owner = -1; m_ptr = 0; m_wait = 0; m_gap = 0;
      return;
    end
    if (((Byte_Valid_In & ~m_gnt) != '0) && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
    m_byte = '0; m_valid = 1'b0; m_ferr = 1'b0; m_terr = 1'b0;
    v = (m_owner >= 0) ? Byte_Valid_In[m_owner] : 1'b0;
    b = (m_owner >= 0) ? Byte_In[10*m_owner +: 10] : 10'h000;
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_owner < 0 && Req[j]) begin
            m_owner = j; m_gnt = '0; m_gnt[j] = 1'b1; m_phase = 1; m_wait = 0;
          end
        end
      end
      1: begin
        if (v && b[9]) begin
          m_byte = b; m_valid = 1'b1;
          if (b[8]) model_release(); else m_phase = 2;
        end else begin
          if (v) m_ferr = 1'b1;
          if (m_wait == TMO - 1) begin m_terr = 1'b1; model_release(); end
          else m_wait++;
        end
      end
      2: begin
        m_valid = 1'b1;
        if (!v) begin m_byte = 10'h100; m_ferr = 1'b1; model_release(); end
        else if (b[9]) begin m_byte = {2'b01, b[7:0]}; m_ferr = 1'b1; model_release(); end
        else begin m_byte = b; if (b[8]) model_release(); end
      end
      default: begin
        m_gap++;
        if (m_gap >= ((IFG == 0) ? 1 : IFG)) m_phase = 0;
      end
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
    cyc++;
    chk("cycle", {Gnt, Eth_Byte_Valid, Eth_Byte, Err_Framing, Err_Timeout, Drop_Cnt},
        {m_gnt, m_valid, m_byte, m_ferr, m_terr, m_drop});
    if (Eth_Byte_Valid && Eth_Byte[8]) last_eop = cyc;
    if (Eth_Byte_Valid && Eth_Byte[9]) last_sop = cyc;
    if (Eth_Byte_Valid) outv_seen++;
    if (Err_Timeout) terr_seen++;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req = '0; Byte_Valid_In = '0; Byte_In = '0;
    step();
    step();
    Rst = 1'b0;
  endtask

  task automatic put(int idx, logic [9:0] b);
    Byte_Valid_In = '0; Byte_Valid_In[idx] = 1'b1;
    Byte_In = '0; Byte_In[10*idx +: 10] = b;
    step();
    Byte_Valid_In = '0; Byte_In = '0;
  endtask

  task automatic wait_gnt(output int idx);
    int n;
    n = 0; idx = -1;
    while (Gnt == '0 && n < 200) begin step(); n++; end
    tests++;
    if (Gnt == '0) begin
      fails++;
      $display("FAIL wait_gnt: no grant within 200 cycles (cycle %0d)", cyc);
    end else begin
      for (int i = 0; i < N; i++) if (Gnt[i]) idx = i;
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         vld;
    logic [9:0]   b0;
    logic [N-1:0] e_gnt;
    logic         e_valid;
    logic [9:0]   e_byte;
  } vec_t;

  vec_t tbl [30];

  initial begin
    int g;
    int t;
    int order [4];

    // Test 1: single req0 packet, vector table
    tbl[0] = '{3'b001, 1'b0, 10'h000, 3'b001, 1'b0, 10'h000};
    tbl[1] = '{3'b001, 1'b1, 10'h210, 3'b001, 1'b1, 10'h210};
    tbl[2] = '{3'b001, 1'b1, 10'h011, 3'b001, 1'b1, 10'h011};
    tbl[3] = '{3'b001, 1'b1, 10'h022, 3'b001, 1'b1, 10'h022};
    tbl[4] = '{3'b001, 1'b1, 10'h133, 3'b000, 1'b1, 10'h133};
    for (int r = 5; r < 29; r++) tbl[r] = '{3'b001, 1'b0, 10'h000, 3'b000, 1'b0, 10'h000};
    tbl[29] = '{3'b001, 1'b0, 10'h000, 3'b001, 1'b0, 10'h000};

    do_reset();
    for (int r = 0; r < 30; r++) begin
      Req = tbl[r].req;
      Byte_Valid_In = {2'b00, tbl[r].vld};
      Byte_In = '0; Byte_In[9:0] = tbl[r].b0;
      step();
      chk($sformatf("tbl[%0d]", r), {Gnt, Eth_Byte_Valid, Eth_Byte},
          {tbl[r].e_gnt, tbl[r].e_valid, tbl[r].e_byte});
    end

    // Test 2: all requesting, round-robin order and gap
    do_reset();
    Req = 3'b111;
    for (int p = 0; p < 4; p++) begin
      wait_gnt(g);
      order[p] = g;
      put(g, 10'h200 + 10'(p));
      if (p > 0) chk("ifg_gap", 32'(last_sop - last_eop), 32'd26);
      put(g, 10'h180 + 10'(p));
    end
    chk("order0", 32'(order[0]), 32'd0);
    chk("order1", 32'(order[1]), 32'd1);
    chk("order2", 32'(order[2]), 32'd2);
    chk("order3", 32'(order[3]), 32'd0);

    // Test 3: grantee never starts
    do_reset();
    Req = 3'b010;
    wait_gnt(g);
    chk("tmo_grant", 32'(g), 32'd1);
    Req = 3'b111;
    terr_seen = 0;
    t = 0;
    while (!Err_Timeout && t < 200) begin step(); t++; end
    chk("tmo_cycle", 32'(t), 32'd64);
    chk("tmo_gnt_off", {29'd0, Gnt}, 32'd0);
    wait_gnt(g);
    chk("tmo_next_grant", 32'(g), 32'd2);
    chk("tmo_once", 32'(terr_seen), 32'd1);

    // Test 4: underrun after two bytes
    do_reset();
    Req = 3'b001;
    wait_gnt(g);
    Req = '0;
    put(0, 10'h2AA);
    put(0, 10'h055);
    step();
    chk("underrun_byte", {Eth_Byte_Valid, Eth_Byte}, {1'b1, 10'h100});
    chk("underrun_ferr", {31'd0, Err_Framing}, 32'd1);
    chk("underrun_gnt", {29'd0, Gnt}, 32'd0);

    // Test 5: non-grantee strobes are dropped and counted, counter saturates
    do_reset();
    Req = 3'b001;
    wait_gnt(g);
    Req = '0;
    outv_seen = 0;
    for (int k = 0; k < 5; k++) put(2, 10'h2C0 + 10'(k));
    step();
    chk("drop_cnt5", {16'd0, Drop_Cnt}, 32'd5);
    chk("drop_no_fwd", 32'(outv_seen), 32'd0);
    force dut.Drop_Cnt = 16'hFFFE;
    m_drop = 16'hFFFE;
    Byte_Valid_In = 3'b100;
    @(posedge Clk);
    model_step();
    #1;
    release dut.Drop_Cnt;
    cyc++;
    step();
    chk("drop_sat", {16'd0, Drop_Cnt}, 32'h0000FFFF);
    step();
    step();
    Byte_Valid_In = '0;
    chk("drop_sat_hold", {16'd0, Drop_Cnt}, 32'h0000FFFF);

    // Test 6: reset mid-transfer
    do_reset();
    Req = 3'b001;
    wait_gnt(g);
    Req = '0;
    put(0, 10'h201);
    put(0, 10'h102);
    Req = 3'b010;
    wait_gnt(g);
    Req = '0;
    put(1, 10'h233);
    Byte_Valid_In = 3'b010; Byte_In = '0; Byte_In[19:10] = 10'h044;
    Rst = 1'b1;
    step();
    chk("rst_outputs", {Gnt, Eth_Byte_Valid, Eth_Byte, Err_Framing, Err_Timeout, Drop_Cnt}, 32'd0);
    Rst = 1'b0; Byte_Valid_In = '0; Byte_In = '0;
    Req = 3'b011;
    step();
    chk("rst_ptr_zero", {29'd0, Gnt}, 32'd1);
    do_reset();
    Req = 3'b010;
    step();
    chk("rst_then_req1", {29'd0, Gnt}, 32'd2);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      Rst = ($urandom_range(499) == 0);
      Req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        Byte_Valid_In[i] = ($urandom_range(1) == 0);
        Byte_In[10*i +: 10] = {($urandom_range(3) == 0), ($urandom_range(3) == 0), 8'($urandom)};
      end
      step();
    end
    Rst = 1'b0; Req = '0; Byte_Valid_In = '0; Byte_In = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
